// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline hazard/stall logic:
//   - pipe_state_e  : sequencer states (RUN, MEM_WAIT, DRAIN, HALTED)
//   - stage_ctrl_t  : write-enable / flush bundle for PC and pipeline registers
//   - MEMTOREG_*    : write-back destination selects used by the hazard unit
//   - stage_priority: per-cycle stall/flush decision for an active pipeline
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DRAIN_CYC_DEF   = 4;
    localparam int MEM_TIMEOUT_DEF = 255;

    // MemtoReg select value that marks an instruction as a load; the hazard
    // unit compares against it to detect load-use dependencies.
    localparam logic [1:0] MEMTOREG_SEL_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_SEL_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    // Priority-ordered stall/flush decision. A register that loads a bubble
    // keeps its WE high: it advances, just with an empty slot.
    function automatic stage_ctrl_t stage_priority(
        input logic mem_hold,
        input logic need_stall,
        input logic branch_taken,
        input logic imem_ready
    );
        stage_ctrl_t c;
        c = '0;
        if (mem_hold) begin
            // Everything up to EX/MEM freezes; MEM/WB receives a bubble.
            c.memwb_we    = 1'b1;
            c.memwb_flush = 1'b1;
        end else if (need_stall) begin
            // Hold the dependent instruction, insert one bubble into EX/MEM.
            c.exmem_we    = 1'b1;
            c.memwb_we    = 1'b1;
            c.exmem_flush = 1'b1;
        end else if (branch_taken) begin
            c.pc_we       = 1'b1;
            c.ifid_we     = 1'b1;
            c.idex_we     = 1'b1;
            c.exmem_we    = 1'b1;
            c.memwb_we    = 1'b1;
            c.ifid_flush  = 1'b1;
            c.idex_flush  = 1'b1;
        end else if (!imem_ready) begin
            // Fetch not done: hold PC and IF/ID, let the back end drain.
            c.idex_we     = 1'b1;
            c.exmem_we    = 1'b1;
            c.memwb_we    = 1'b1;
            c.idex_flush  = 1'b1;
        end else begin
            c.pc_we       = 1'b1;
            c.ifid_we     = 1'b1;
            c.idex_we     = 1'b1;
            c.exmem_we    = 1'b1;
            c.memwb_we    = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_sat_counter
// Saturating up-counter used for the stall and flush performance counters.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset (clears the count)
//   i_clear  : synchronous clear
//   i_inc    : increment request (ignored once the count is all-ones)
//   o_count  : current count
// ---------------------------------------------------------------------------
module pipeline_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Combines the
// load-use stall, EX branch decision and memory ready handshakes into
// write-enables and bubble-flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Also sequences halt/drain and keeps saturating stall/flush counters.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   Need_Stall                 : load-use hazard from the hazard unit
//   EX_Branch_Taken            : branch/jump resolved taken in EX
//   IMem_Ready                 : instruction fetch completes this cycle
//   EXmem__MemEnable           : EX/MEM holds a memory access
//   DMem_Ready                 : data access completes this cycle
//   Halt_Req / Resume          : halt level request / resume pulse
//   *_WE / *_Flush             : per-register update enable / bubble load
//   Halted                     : pipeline empty and frozen
//   Mem_Timeout                : sticky data-memory timeout flag
//   Stall_Cnt / Flush_Cnt      : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DRAIN_CYC   = DRAIN_CYC_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Need_Stall,
    input  logic             EX_Branch_Taken,
    input  logic             IMem_Ready,
    input  logic             EXmem__MemEnable,
    input  logic             DMem_Ready,
    input  logic             Halt_Req,
    input  logic             Resume,
    output logic             PC_WE,
    output logic             IFid_WE,
    output logic             IDex_WE,
    output logic             EXmem_WE,
    output logic             MEMwb_WE,
    output logic             IFid_Flush,
    output logic             IDex_Flush,
    output logic             EXmem_Flush,
    output logic             MEMwb_Flush,
    output logic             Halted,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    pipe_state_e        r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_ret_drain;   // MEM_WAIT was entered from DRAIN
    logic               r_halt_block;  // Halt_Req must drop before it counts again
    logic               r_mem_timeout;

    stage_ctrl_t        w_ctrl;
    logic               w_active;
    logic               w_dmem_wait;
    logic               w_mem_hold;
    logic               w_in_drain;
    logic               w_branch_fire;
    logic               w_stall_inc;
    logic               w_drain_last;
    logic               w_halt_take;
    logic [1:0]         w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_val [2];

    assign w_dmem_wait  = EXmem__MemEnable && !DMem_Ready;
    assign w_drain_last = (r_drain_cnt <= DRAIN_W'(1));
    assign w_halt_take  = Halt_Req && !r_halt_block;

    // ---------------------------------------------------------------------
    // Enables and flushes: combinational from state, inputs and reset.
    // ---------------------------------------------------------------------
    always_comb begin
        w_active      = (r_state != HALTED);
        // Inside MEM_WAIT the held access is already in EX/MEM, so only the
        // ready handshake decides whether we are still waiting.
        w_mem_hold    = (r_state == MEM_WAIT) ? !DMem_Ready : w_dmem_wait;
        w_in_drain    = (r_state == DRAIN) || ((r_state == MEM_WAIT) && r_ret_drain);
        w_ctrl        = '0;
        w_branch_fire = 1'b0;
        if (w_active) begin
            w_ctrl        = stage_priority(w_mem_hold, Need_Stall, EX_Branch_Taken, IMem_Ready);
            w_branch_fire = !w_mem_hold && !Need_Stall && EX_Branch_Taken;
            if (w_in_drain) begin
                // Fetch is stopped: nothing new enters, IF/ID is emptied.
                w_ctrl.pc_we      = 1'b0;
                w_ctrl.ifid_flush = 1'b1;
            end
        end
        if (!rst_n) begin
            w_ctrl             = '0;
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_ctrl.exmem_flush = 1'b1;
            w_ctrl.memwb_flush = 1'b1;
            w_branch_fire      = 1'b0;
        end
    end

    assign PC_WE       = w_ctrl.pc_we;
    assign IFid_WE     = w_ctrl.ifid_we;
    assign IDex_WE     = w_ctrl.idex_we;
    assign EXmem_WE    = w_ctrl.exmem_we;
    assign MEMwb_WE    = w_ctrl.memwb_we;
    assign IFid_Flush  = w_ctrl.ifid_flush;
    assign IDex_Flush  = w_ctrl.idex_flush;
    assign EXmem_Flush = w_ctrl.exmem_flush;
    assign MEMwb_Flush = w_ctrl.memwb_flush;

    assign Halted      = (r_state == HALTED);
    assign Mem_Timeout = r_mem_timeout;

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_drain_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_ret_drain   <= 1'b0;
            r_halt_block  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (!Halt_Req) begin
                r_halt_block <= 1'b0;
            end
            unique case (r_state)
                RUN: begin
                    if (w_dmem_wait) begin
                        r_state     <= MEM_WAIT;
                        r_ret_drain <= 1'b0;
                        r_wait_cnt  <= WAIT_W'(1);
                        if (MEM_TIMEOUT <= 1) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end else if (w_halt_take) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= DRAIN_W'(DRAIN_CYC);
                    end
                end
                DRAIN: begin
                    if (w_dmem_wait) begin
                        // Back end frozen: the drain count does not move.
                        r_state     <= MEM_WAIT;
                        r_ret_drain <= 1'b1;
                        r_wait_cnt  <= WAIT_W'(1);
                        if (MEM_TIMEOUT <= 1) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end else if (w_drain_last) begin
                        r_state     <= HALTED;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (DMem_Ready) begin
                        r_wait_cnt <= '0;
                        if (!r_ret_drain) begin
                            r_state <= RUN;
                        end else if (w_drain_last) begin
                            // The completing cycle advances the back end, so
                            // it counts as a drain step.
                            r_state     <= HALTED;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                        end
                    end else begin
                        if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                        if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (Resume) begin
                        r_state      <= RUN;
                        // A level still high at resume is stale.
                        r_halt_block <= Halt_Req;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters: [0] stall cycles, [1] branch flush events.
    // ---------------------------------------------------------------------
    assign w_stall_inc  = w_active && !w_ctrl.pc_we;
    assign w_cnt_inc[0] = w_stall_inc;
    assign w_cnt_inc[1] = w_branch_fire;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            pipeline_ctrl_sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clear (1'b0),
                .i_inc   (w_cnt_inc[gi]),
                .o_count (w_cnt_val[gi])
            );
        end
    endgenerate

    assign Stall_Cnt = w_cnt_val[0];
    assign Flush_Cnt = w_cnt_val[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the stall/flush/halt rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int CNT_W       = 6;
    localparam int DRAIN_CYC   = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Need_Stall = 1'b0, EX_Branch_Taken = 1'b0, IMem_Ready = 1'b1;
    logic EXmem__MemEnable = 1'b0, DMem_Ready = 1'b0;
    logic Halt_Req = 1'b0, Resume = 1'b0;
    logic PC_WE, IFid_WE, IDex_WE, EXmem_WE, MEMwb_WE;
    logic IFid_Flush, IDex_Flush, EXmem_Flush, MEMwb_Flush;
    logic Halted, Mem_Timeout;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .CNT_W       (CNT_W),
        .DRAIN_CYC   (DRAIN_CYC),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Need_Stall       (Need_Stall),
        .EX_Branch_Taken  (EX_Branch_Taken),
        .IMem_Ready       (IMem_Ready),
        .EXmem__MemEnable (EXmem__MemEnable),
        .DMem_Ready       (DMem_Ready),
        .Halt_Req         (Halt_Req),
        .Resume           (Resume),
        .PC_WE            (PC_WE),
        .IFid_WE          (IFid_WE),
        .IDex_WE          (IDex_WE),
        .EXmem_WE         (EXmem_WE),
        .MEMwb_WE         (MEMwb_WE),
        .IFid_Flush       (IFid_Flush),
        .IDex_Flush       (IDex_Flush),
        .EXmem_Flush      (EXmem_Flush),
        .MEMwb_Flush      (MEMwb_Flush),
        .Halted           (Halted),
        .Mem_Timeout      (Mem_Timeout),
        .Stall_Cnt        (Stall_Cnt),
        .Flush_Cnt        (Flush_Cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    bit m_wait, m_drain, m_halt, m_blocked, m_tmo;
    int m_drain_left, m_wait_len, m_stall, m_flush;

    task automatic model_reset();
        m_wait = 0; m_drain = 0; m_halt = 0; m_blocked = 0; m_tmo = 0;
        m_drain_left = 0; m_wait_len = 0; m_stall = 0; m_flush = 0;
    endtask

    // Expected vector {PC,IFid,IDex,EXmem,MEMwb WE, IFid,IDex,EXmem,MEMwb Flush}
    task automatic model_outputs(output int vec, output bit fire);
        bit hold;
        vec  = 0;
        fire = 0;
        if (!rst_n) begin
            vec = 9'b00000_1111;
            return;
        end
        if (m_halt) return;
        hold = m_wait ? !DMem_Ready : (EXmem__MemEnable && !DMem_Ready);
        if (hold)                 vec = 9'b00001_0001;
        else if (Need_Stall)      vec = 9'b00011_0010;
        else if (EX_Branch_Taken) begin vec = 9'b11111_1100; fire = 1; end
        else if (!IMem_Ready)     vec = 9'b00111_0100;
        else                      vec = 9'b11111_0000;
        if (m_drain) begin
            vec[8] = 1'b0;
            vec[3] = 1'b1;
        end
    endtask

    task automatic drain_advance();
        m_drain_left--;
        if (m_drain_left <= 0) begin
            m_drain = 0;
            m_halt  = 1;
        end
    endtask

    task automatic model_step(input int vec, input bit fire);
        if (!rst_n) return;
        if (!m_halt && !vec[8] && m_stall < CNT_MAX) m_stall++;
        if (fire && m_flush < CNT_MAX) m_flush++;
        if (!Halt_Req) m_blocked = 0;
        if (m_halt) begin
            if (Resume) begin
                m_halt    = 0;
                m_blocked = Halt_Req;
            end
        end else if (m_wait) begin
            if (DMem_Ready) begin
                m_wait     = 0;
                m_wait_len = 0;
                if (m_drain) drain_advance();
            end else begin
                m_wait_len++;
                if (m_wait_len >= MEM_TIMEOUT) m_tmo = 1;
            end
        end else if (EXmem__MemEnable && !DMem_Ready) begin
            m_wait     = 1;
            m_wait_len = 1;
            if (m_wait_len >= MEM_TIMEOUT) m_tmo = 1;
        end else if (m_drain) begin
            drain_advance();
        end else if (Halt_Req && !m_blocked) begin
            m_drain      = 1;
            m_drain_left = DRAIN_CYC;
        end
    endtask

    // ---------------- stimulus / checking ----------------
    task automatic set_inputs(input bit ns, br, im, me, dr, hr, rs);
        Need_Stall = ns; EX_Branch_Taken = br; IMem_Ready = im;
        EXmem__MemEnable = me; DMem_Ready = dr; Halt_Req = hr; Resume = rs;
    endtask

    task automatic check_now(input string tag, input bit verbose, output int vec, output bit fire);
        logic [8:0] got;
        model_outputs(vec, fire);
        got = {PC_WE, IFid_WE, IDex_WE, EXmem_WE, MEMwb_WE,
               IFid_Flush, IDex_Flush, EXmem_Flush, MEMwb_Flush};
        check_val({tag, ".ctrl"},    int'(got),         vec);
        check_val({tag, ".stall"},   int'(Stall_Cnt),   m_stall);
        check_val({tag, ".flush"},   int'(Flush_Cnt),   m_flush);
        check_val({tag, ".halted"},  int'(Halted),      int'(m_halt));
        check_val({tag, ".timeout"}, int'(Mem_Timeout), int'(m_tmo));
        if (verbose)
            $display("[%0t] %-12s in(ns br im me dr hr rs)=%b%b%b%b%b%b%b ctrl=%b stall=%0d flush=%0d halted=%b tmo=%b",
                     $time, tag, Need_Stall, EX_Branch_Taken, IMem_Ready, EXmem__MemEnable,
                     DMem_Ready, Halt_Req, Resume, got, Stall_Cnt, Flush_Cnt, Halted, Mem_Timeout);
    endtask

    task automatic tick(input string tag, input bit ns, br, im, me, dr, hr, rs, input bit verbose);
        int vec;
        bit fire;
        @(negedge clk);
        set_inputs(ns, br, im, me, dr, hr, rs);
        #2;
        check_now(tag, verbose, vec, fire);
        model_step(vec, fire);
    endtask

    task automatic apply_reset();
        int vec;
        bit fire;
        @(negedge clk);
        set_inputs(0, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_now("reset", 1, vec, fire);
        @(negedge clk);
        #2;
        check_now("reset_hold", 1, vec, fire);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int vec;
        bit fire;
        bit hr;

        model_reset();
        apply_reset();

        // Idle RUN
        for (int i = 0; i < 10; i++) tick("idle", 0, 0, 1, 0, 0, 0, 0, 1);

        // Single load-use stall, then branch suppressed by a stall
        tick("ld_use",   1, 0, 1, 0, 0, 0, 0, 1);
        tick("after_ld", 0, 0, 1, 0, 0, 0, 0, 1);
        tick("br_stall", 1, 1, 1, 0, 0, 0, 0, 1);
        tick("br_only",  0, 1, 1, 0, 0, 0, 0, 1);
        tick("post_br",  0, 0, 1, 0, 0, 0, 0, 1);
        check_val("br_flush_cnt", int'(Flush_Cnt), 1);
        check_val("br_stall_cnt", int'(Stall_Cnt), 2);

        // Instruction fetch not ready
        tick("imem_wait", 0, 0, 0, 0, 0, 0, 0, 1);

        // Data memory wait of three cycles
        apply_reset();
        tick("mw1", 0, 0, 1, 1, 0, 0, 0, 1);
        tick("mw2", 0, 0, 1, 1, 0, 0, 0, 1);
        tick("mw3", 0, 0, 1, 1, 0, 0, 0, 1);
        tick("mw_done", 0, 0, 1, 1, 1, 0, 0, 1);
        tick("mw_after", 0, 0, 1, 0, 0, 0, 0, 1);
        check_val("mw_stall_cnt", int'(Stall_Cnt), 3);

        // Data memory timeout stays sticky
        apply_reset();
        for (int i = 0; i < 6; i++) tick("tmo_wait", 0, 0, 1, 1, 0, 0, 0, 1);
        tick("tmo_ready", 0, 0, 1, 1, 1, 0, 0, 1);
        tick("tmo_after", 0, 0, 1, 0, 0, 0, 0, 1);
        tick("tmo_after", 0, 0, 1, 0, 0, 0, 0, 1);
        check_val("tmo_sticky", int'(Mem_Timeout), 1);

        // Halt with one data wait cycle inside the drain
        apply_reset();
        tick("halt_req", 0, 0, 1, 0, 0, 1, 0, 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick("drain", 0, 0, 1, (k == 1), (k != 1), 1, 0, 1);
            if (Halted) break;
            n++;
        end
        check_val("halt_latency", n, 5);
        tick("halted", 0, 1, 1, 0, 0, 1, 0, 1);
        tick("resume", 0, 0, 1, 0, 0, 1, 1, 1);
        tick("run_again", 0, 0, 1, 0, 0, 1, 0, 1);
        check_val("resume_pc_we", int'(PC_WE), 1);
        tick("stale_halt", 0, 0, 1, 0, 0, 1, 0, 1);
        tick("stale_halt", 0, 0, 1, 0, 0, 1, 0, 1);
        tick("halt_low", 0, 0, 1, 0, 0, 0, 0, 1);
        tick("halt_again", 0, 0, 1, 0, 0, 1, 0, 1);
        tick("drain2", 0, 1, 1, 0, 0, 1, 0, 1);
        check_val("drain2_pc_we", int'(PC_WE), 0);
        tick("drain2", 0, 0, 1, 0, 0, 1, 0, 1);

        // Asynchronous reset in the middle of a drain
        @(posedge clk);
        #2;
        set_inputs(0, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now("async_rst", 1, vec, fire);
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_async", 0, 0, 1, 0, 0, 0, 0, 1);

        // Randomized traffic in several reset segments
        for (int seg = 0; seg < 6; seg++) begin
            apply_reset();
            hr = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 19) == 0) hr = ~hr;
                tick("rand",
                     ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 99) < 85),
                     ($urandom_range(0, 99) < 30),
                     ($urandom_range(0, 99) < 70),
                     hr,
                     ($urandom_range(0, 99) < 20),
                     0);
            end
            $display("random segment %0d: 500 cycles, checks so far %0d", seg, n_checks);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Consumes the hazard unit's load-use Need_Stall, the EX-stage branch decision, and the instruction/data memory ready handshakes.
- Drives the write-enable and flush (bubble) of the PC and of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Also implements a halt/drain sequence and stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- DRAIN_CYC, 4, cycles of pipeline drain after a halt request before Halted asserts.
- MEM_TIMEOUT, 255, maximum consecutive data-memory wait cycles before Mem_Timeout sets.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- Need_Stall  in  1  load-use hazard (load in EX/MEM, dependent instruction in ID/EX).
- EX_Branch_Taken  in  1  branch/jump resolved taken in EX this cycle.
- IMem_Ready  in  1  instruction fetch completes this cycle.
- EXmem__MemEnable  in  1  EX/MEM holds a memory access.
- DMem_Ready  in  1  data access completes this cycle.
- Halt_Req  in  1  level request to halt fetch and drain.
- Resume  in  1  pulse; leave HALTED.
- PC_WE, IFid_WE, IDex_WE, EXmem_WE, MEMwb_WE  out  1 each  register update enables.
- IFid_Flush, IDex_Flush, EXmem_Flush, MEMwb_Flush  out  1 each  load a bubble (clear valid/control) instead of data.
- Halted  out  1  pipeline empty and frozen.
- Mem_Timeout  out  1  sticky error flag.
- Stall_Cnt  out  CNT_W  cycles with any stage frozen.
- Flush_Cnt  out  CNT_W  branch flush events.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset state RUN.
- Enables and flushes are combinational from state and inputs. Counters, flags and the drain counter are registered.
- While rst_n is low:
  - all *_WE = 0 and all *_Flush = 1;
  - Halted = 0, Mem_Timeout = 0, counters = 0.
- Condition priority, evaluated each cycle in RUN or DRAIN (first match wins):
  1. dmem_wait = EXmem__MemEnable && !DMem_Ready: PC/IFid/IDex/EXmem WE = 0, MEMwb_Flush = 1. Next state MEM_WAIT.
  2. Need_Stall: PC/IFid/IDex WE = 0, EXmem_Flush = 1, MEMwb_WE = 1. Exactly one bubble per asserted cycle.
  3. EX_Branch_Taken: all WE = 1, IFid_Flush = 1, IDex_Flush = 1. Flush_Cnt += 1.
  4. !IMem_Ready: PC/IFid WE = 0, IDex_Flush = 1, EXmem/MEMwb WE = 1.
  5. Otherwise all WE = 1, no flush.
- Branch coinciding with Need_Stall or dmem_wait is suppressed. The branch stays in ID/EX and is re-evaluated next cycle.
- Flush dominates WE on the same register.
- MEM_WAIT state:
  - same outputs as condition 1;
  - wait counter increments each cycle;
  - on DMem_Ready: outputs as RUN (priorities 2-5 apply in that cycle) and return to the previous state (RUN or DRAIN). The wait counter clears.
  - when the wait counter reaches MEM_TIMEOUT: Mem_Timeout sets and holds until reset, and the state stays MEM_WAIT.
- Halt_Req sampled high in RUN (not MEM_WAIT): next state DRAIN, drain counter loaded with DRAIN_CYC.
- DRAIN state:
  - PC_WE = 0, IFid_Flush = 1; the remaining stages advance per the priorities;
  - the drain counter decrements only on cycles where EXmem/MEMwb advance, i.e. not during dmem_wait. A branch during drain is flushed normally;
  - at counter 0: next state HALTED.
- HALTED state:
  - all WE = 0, no flush, Halted = 1;
  - Resume: next state RUN, Halted = 0 the following cycle;
  - Halt_Req still high when Resume arrives is ignored until it deasserts and reasserts (edge-qualified).
- Stall_Cnt increments on any cycle with PC_WE = 0, excluding HALTED.
- Both counters saturate at all-ones and never wrap.
- Asynchronous reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately with the reset outputs.

Decomposition:
- Shared hazard package holds:
  - state enum (RUN, MEM_WAIT, DRAIN, HALTED);
  - the stage-control bundle typedef (we/flush per stage);
  - the MemtoReg destination-select constant used by the hazard unit.
- One sub-module: sat_counter (parameterised width, inc, clear) instantiated for Stall_Cnt and Flush_Cnt.

Test Plan:
- Reset, then idle RUN with IMem_Ready = 1: all WE = 1, no flushes, Stall_Cnt = 0 after 10 cycles.
- Need_Stall for 1 cycle: PC/IFid/IDex WE = 0, EXmem_Flush = 1 that cycle only; Stall_Cnt = 1.
- EX_Branch_Taken together with Need_Stall, then branch alone the next cycle: first cycle stall only; second cycle IFid_Flush = IDex_Flush = 1; Flush_Cnt = 1.
- EXmem__MemEnable with DMem_Ready low for 3 cycles: MEM_WAIT for 3 cycles with MEMwb_Flush = 1; resumes on cycle 4; Stall_Cnt = 3.
- DMem_Ready held low with MEM_TIMEOUT = 4: Mem_Timeout rises after the 4th wait cycle and stays set through the subsequent DMem_Ready.
- Halt_Req in RUN with DRAIN_CYC = 4, one dmem wait cycle inserted: Halted asserts 5 cycles later. Resume: RUN, all WE = 1 the next cycle.
